bin_cnt_sweep_ctrl: RTL and testbench
=====================================

Name: bin_cnt_sweep_ctrl

Overview:
- Upstream controller for the team's universal binary counter. It drives that counter's syn_clr/load/en/up/d inputs and reads back its q.
- It sweeps the counter from a configured start value to an end value, in either direction, for a programmed number of passes. It flags each terminal count and the end of the sweep.
- Sits between the register/config logic (valid/ready handshake) and one counter instance.

Parameters:
- N, 4, counter width; must match the attached counter.
- R, 4, width of the repetition field.
- P, 8, prescaler width; used only when SWEEP_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock; the attached counter uses the same clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  sweep request valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_start  in  N  first count value.
- cfg_end  in  N  terminal count value.
- cfg_reps  in  R  number of passes; 0 means run until abort.
- abort  in  1  stop the sweep and clear the counter.
- q_in  in  N  counter q.
- cnt_syn_clr  out  1  to counter syn_clr.
- cnt_load  out  1  to counter load.
- cnt_d  out  N  to counter d; always the latched start value.
- cnt_en  out  1  to counter en.
- cnt_up  out  1  to counter up.
- busy  out  1  high in LOAD or RUN.
- tc_pulse  out  1  one-cycle pulse per completed pass.
- done  out  1  one-cycle pulse when the final pass completes.

Behaviour:
- Reset: state=IDLE. All latched config registers=0. Pass counter=0.
  - Resulting outputs: cfg_ready=1; all cnt_*, busy, tc_pulse and done =0.
- All cnt_* outputs are combinational decodes of the registered state, the latched config and q_in. No extra pipeline stage. Counter q therefore reflects a command one cycle later.
- Handshake: a request is accepted when cfg_valid && cfg_ready at a clock edge.
  - On accept, latch start_r, end_r, reps_r, and up_r = (cfg_end >= cfg_start). Clear pass_cnt.
  - Next state is LOAD.
  - cfg_* are ignored at all other times.
- LOAD (1 cycle): cnt_load=1, cnt_d=start_r, cnt_en=0. Next state RUN, so q_in=start_r on the first RUN cycle.
- RUN: cnt_up=up_r at all times.
  - If q_in != end_r: cnt_en=1.
  - If q_in == end_r, the pass is complete:
    - tc_pulse=1 and pass_cnt increments (wraps modulo 2^R).
    - If reps_r != 0 and pass_cnt+1 == reps_r: done=1, cnt_en=0, next state IDLE. The counter holds end_r.
    - Otherwise: cnt_load=1 with d=start_r, and stay in RUN. The next pass starts with no gap cycle.
- A pass from s to e occupies |e-s|+1 RUN cycles.
- start==end: every RUN cycle is a terminal cycle, so tc_pulse is high continuously for reps_r cycles.
- No wrap-around sweeps: the direction is fixed by comparison. Example: start=14, end=2 counts down 14..2 and never passes through 15/0.
- abort: highest priority, and only acts in LOAD or RUN.
  - cnt_syn_clr=1 for that cycle; all other cnt_* are 0.
  - tc_pulse=0 and done=0; next state IDLE.
  - abort in IDLE is ignored.
- IDLE: all cnt_* are 0, so the counter holds its value.
- Reset mid-sweep returns the block to IDLE immediately. The attached counter shares rst and clears too.

Optional Feature:
- Macro: SWEEP_PRESCALE_EN.
- Defined:
  - Adds input cfg_presc[P-1:0], latched on accept.
  - A down-counter reloads to presc_r on entry to RUN and on every tick.
  - "tick" = prescale counter == 0.
  - In RUN, cnt_en and all terminal actions (tc_pulse, pass_cnt, reload, done) are qualified by tick. Every count value, including end_r, is held for presc_r+1 cycles.
  - presc=0 behaves exactly like the macro-undefined build.
  - abort still acts immediately.
- Undefined: no cfg_presc port; tick is constant 1.

Test Plan (N=4, R=4, counter attached):
- Up sweep: start=3, end=6, reps=1.
  - Response: q = 3,4,5,6 over the RUN cycles.
  - tc_pulse and done coincide in the q=6 cycle; cfg_ready=1 on the next cycle; q holds 6.
- Down multi-pass: start=9, end=7, reps=3.
  - Response: q = 9,8,7,9,8,7,9,8,7, with tc_pulse at each 7.
  - done only at the third 7; busy is high for 10 cycles.
- Degenerate and infinite runs:
  - start=end=5, reps=2: tc_pulse high for 2 consecutive cycles, then done.
  - reps=0, start=0, end=15: sweeps repeat indefinitely, done never fires. Then abort: cnt_syn_clr for one cycle, q=0 next cycle, IDLE.
- Handshake: cfg_valid held with new values during RUN is ignored. A new request is accepted only in the cycle after done; cfg_ready=0 throughout busy.
- Reset mid-RUN: rst asserted at q=4 of a 2..10 sweep.
  - During rst: all outputs at reset values asynchronously, q=0.
  - After rst release: IDLE, cfg_ready=1.
- SWEEP_PRESCALE_EN build: presc=2, start=1, end=3, reps=1.
  - Response: each of 1,2,3 is held 3 cycles; done fires in the last cycle of 3.
  - presc=0 matches the undefined build cycle-for-cycle.

Source files
------------

// File: rtl/bin_cnt_sweep_ctrl.sv
// Sweep controller for the universal binary counter: walks the counter from a latched start to end value for a
// programmed number of passes. Optional per-step prescaler enabled by defining SWEEP_PRESCALE_EN.
module bin_cnt_sweep_ctrl #(
  parameter int N = 4,
  parameter int R = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [N-1:0] cfg_start,
  input  logic [N-1:0] cfg_end,
  input  logic [R-1:0] cfg_reps,
`ifdef SWEEP_PRESCALE_EN
  input  logic [P-1:0] cfg_presc,
`endif
  input  logic         abort,
  input  logic [N-1:0] q_in,
  output logic         cnt_syn_clr,
  output logic         cnt_load,
  output logic [N-1:0] cnt_d,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic         busy,
  output logic         tc_pulse,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e       state_q;
  logic [N-1:0] start_q;
  logic [N-1:0] end_q;
  logic [R-1:0] reps_q;
  logic         up_q;
  logic [R-1:0] pass_q;
  logic [P-1:0] presc_cnt_q;
  logic [P-1:0] presc_val;
  logic         tick;
  logic         at_end;
  logic         last_pass;

`ifdef SWEEP_PRESCALE_EN
  logic [P-1:0] presc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (state_q == IDLE && cfg_valid) begin
      presc_q <= cfg_presc;
    end
  end

  assign presc_val = presc_q;
`else
  // A zero reload keeps the prescale counter at 0, so every RUN cycle is a tick.
  assign presc_val = '0;
`endif

  assign tick      = (presc_cnt_q == '0);
  assign at_end    = (q_in == end_q);
  assign last_pass = (reps_q != '0) && ((pass_q + R'(1)) == reps_q);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    cfg_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    cnt_d       = start_q;
    cnt_syn_clr = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    cnt_up      = 1'b0;
    tc_pulse    = 1'b0;
    done        = 1'b0;
    case (state_q)
      LOAD: begin
        if (abort) cnt_syn_clr = 1'b1;
        else       cnt_load    = 1'b1;
      end
      RUN: begin
        if (abort) begin
          cnt_syn_clr = 1'b1;
        end else begin
          cnt_up = up_q;
          if (tick) begin
            if (!at_end) begin
              cnt_en = 1'b1;
            end else begin
              tc_pulse = 1'b1;
              if (last_pass) done     = 1'b1;
              else           cnt_load = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      reps_q      <= '0;
      up_q        <= 1'b0;
      pass_q      <= '0;
      presc_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            start_q <= cfg_start;
            end_q   <= cfg_end;
            reps_q  <= cfg_reps;
            up_q    <= (cfg_end >= cfg_start);
            pass_q  <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            presc_cnt_q <= presc_val;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            presc_cnt_q <= tick ? presc_val : presc_cnt_q - P'(1);
            if (tc_pulse) pass_q  <= pass_q + R'(1);
            if (done)     state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_cnt_sweep_ctrl.sv
// Self-checking bench: sweep controller driving a behavioural universal counter, checked against a
// sweep-sequence model built from start/end/reps (and prescale when SWEEP_PRESCALE_EN is defined).
module tb_bin_cnt_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_start = '0;
  logic [3:0] cfg_end = '0;
  logic [3:0] cfg_reps = '0;
`ifdef SWEEP_PRESCALE_EN
  logic [7:0] cfg_presc = '0;
`endif
  logic       abort = 1'b0;
  logic [3:0] q;
  logic       cnt_syn_clr, cnt_load, cnt_en, cnt_up, busy, tc_pulse, done;
  logic [3:0] cnt_d;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q    = 0;
  int presc_v  = 0;

  always #5 clk = ~clk;

  bin_cnt_sweep_ctrl #(.N(4), .R(4), .P(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_end    (cfg_end),
    .cfg_reps   (cfg_reps),
`ifdef SWEEP_PRESCALE_EN
    .cfg_presc  (cfg_presc),
`endif
    .abort      (abort),
    .q_in       (q),
    .cnt_syn_clr(cnt_syn_clr),
    .cnt_load   (cnt_load),
    .cnt_d      (cnt_d),
    .cnt_en     (cnt_en),
    .cnt_up     (cnt_up),
    .busy       (busy),
    .tc_pulse   (tc_pulse),
    .done       (done)
  );

  // Attached universal binary counter: syn_clr over load over count enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              q <= '0;
    else if (cnt_syn_clr) q <= '0;
    else if (cnt_load)    q <= cnt_d;
    else if (cnt_en)      q <= cnt_up ? q + 4'd1 : q - 4'd1;
  end

  typedef struct {
    bit busy;
    int q;
    bit tc;
    bit done;
    bit ready;
    bit load;
    bit en;
    bit up;
  } exp_t;

  typedef struct {
    logic [3:0] s;
    logic [3:0] e;
    logic [3:0] r;
    int         busy_cycles;
    int         tcs;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a request and let it be accepted on the next rising edge.
  task automatic issue(input logic [3:0] s, e, r);
    cfg_valid = 1'b1;
    cfg_start = s;
    cfg_end   = e;
    cfg_reps  = r;
`ifdef SWEEP_PRESCALE_EN
    cfg_presc = presc_v[7:0];
`endif
    #1;
    check("ready_before_accept", int'(cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Expected trace: LOAD, then each pass walks s..e with every value held presc+1 cycles, then one IDLE cycle.
  task automatic trace(input logic [3:0] s, e, r, input int presc, output int busy_n, output int tc_n);
    exp_t exp_list[$];
    exp_t x;
    int   v;
    int   step;
    bit   up;
    up   = (e >= s);
    step = up ? 1 : -1;
    x = '{busy: 1, q: exp_q, tc: 0, done: 0, ready: 0, load: 1, en: 0, up: 0};
    exp_list.push_back(x);
    for (int p = 0; p < int'(r); p++) begin
      v = int'(s);
      forever begin
        for (int k = 0; k <= presc; k++) begin
          x.busy  = 1;
          x.q     = v;
          x.tc    = (k == presc) && (v == int'(e));
          x.done  = x.tc && (p == int'(r) - 1);
          x.ready = 0;
          x.load  = x.tc && !x.done;
          x.en    = (k == presc) && (v != int'(e));
          x.up    = up;
          exp_list.push_back(x);
        end
        if (v == int'(e)) break;
        v += step;
      end
    end
    x = '{busy: 0, q: int'(e), tc: 0, done: 0, ready: 1, load: 0, en: 0, up: 0};
    exp_list.push_back(x);
    busy_n = 0;
    tc_n   = 0;
    foreach (exp_list[i]) begin
      @(negedge clk);
      busy_n += int'(busy);
      tc_n   += int'(tc_pulse);
      check($sformatf("busy[%0d]", i),  int'(busy),      int'(exp_list[i].busy));
      check($sformatf("q[%0d]", i),     int'(q),         exp_list[i].q);
      check($sformatf("tc[%0d]", i),    int'(tc_pulse),  int'(exp_list[i].tc));
      check($sformatf("done[%0d]", i),  int'(done),      int'(exp_list[i].done));
      check($sformatf("ready[%0d]", i), int'(cfg_ready), int'(exp_list[i].ready));
      check($sformatf("load[%0d]", i),  int'(cnt_load),  int'(exp_list[i].load));
      check($sformatf("en[%0d]", i),    int'(cnt_en),    int'(exp_list[i].en));
      check($sformatf("up[%0d]", i),    int'(cnt_up),    int'(exp_list[i].up));
      check($sformatf("clr[%0d]", i),   int'(cnt_syn_clr), 0);
      if (exp_list[i].load) check($sformatf("d[%0d]", i), int'(cnt_d), int'(s));
    end
    exp_q = int'(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(cfg_ready), 1);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_tc"},    int'(tc_pulse), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_cnt"},   int'({cnt_syn_clr, cnt_load, cnt_en, cnt_up}), 0);
    check({tag, "_d"},     int'(cnt_d), 0);
    check({tag, "_q"},     int'(q), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int   bn, tn, len, exp_busy;
    logic [3:0] rs, re, rr;

    vecs[0] = '{s: 4'd3,  e: 4'd6,  r: 4'd1, busy_cycles: 5,  tcs: 1};
    vecs[1] = '{s: 4'd9,  e: 4'd7,  r: 4'd3, busy_cycles: 10, tcs: 3};
    vecs[2] = '{s: 4'd5,  e: 4'd5,  r: 4'd2, busy_cycles: 3,  tcs: 2};
    vecs[3] = '{s: 4'd14, e: 4'd2,  r: 4'd1, busy_cycles: 14, tcs: 1};
    vecs[4] = '{s: 4'd0,  e: 4'd15, r: 4'd1, busy_cycles: 17, tcs: 1};
    vecs[5] = '{s: 4'd15, e: 4'd0,  r: 4'd2, busy_cycles: 33, tcs: 2};

    // Reset state
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Table-driven sweeps
    foreach (vecs[i]) begin
      issue(vecs[i].s, vecs[i].e, vecs[i].r);
      trace(vecs[i].s, vecs[i].e, vecs[i].r, 0, bn, tn);
      check($sformatf("vec%0d_busy_cycles", i), bn, vecs[i].busy_cycles);
      check($sformatf("vec%0d_tc_count", i),    tn, vecs[i].tcs);
    end

    // Handshake: request held during a sweep is ignored, then accepted in the IDLE cycle after done
    issue(4'd3, 4'd6, 4'd1);
    cfg_valid = 1'b1;
    cfg_start = 4'd9;
    cfg_end   = 4'd7;
    cfg_reps  = 4'd3;
    trace(4'd3, 4'd6, 4'd1, 0, bn, tn);
    check("hs_first_busy", bn, 5);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    trace(4'd9, 4'd7, 4'd3, 0, bn, tn);
    check("hs_second_busy", bn, 10);
    check("hs_second_tc", tn, 3);

    // Infinite run (reps=0), then abort mid-pass
    issue(4'd0, 4'd15, 4'd0);
    @(negedge clk);
    check("inf_load", int'(cnt_load), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("inf_q[%0d]", i),    int'(q), i % 16);
      check($sformatf("inf_tc[%0d]", i),   int'(tc_pulse), int'(i % 16 == 15));
      check($sformatf("inf_done[%0d]", i), int'(done), 0);
      check($sformatf("inf_busy[%0d]", i), int'(busy), 1);
    end
    abort = 1'b1;
    #1;
    check("abort_clr",  int'(cnt_syn_clr), 1);
    check("abort_cnt",  int'({cnt_load, cnt_en, cnt_up}), 0);
    check("abort_tc",   int'(tc_pulse), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_q",     int'(q), 0);
    check("abort_busy",  int'(busy), 0);
    check("abort_ready", int'(cfg_ready), 1);
    exp_q = 0;

    // Abort in IDLE is ignored
    abort = 1'b1;
    #1;
    check("idle_abort_clr", int'(cnt_syn_clr), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("idle_abort_ready", int'(cfg_ready), 1);

    // Abort during LOAD
    issue(4'd4, 4'd8, 4'd1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("load_abort_clr",  int'(cnt_syn_clr), 1);
    check("load_abort_load", int'(cnt_load), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("load_abort_busy", int'(busy), 0);
    check("load_abort_q",    int'(q), 0);

    // Reset mid-RUN at q=4 of a 2..10 sweep
    issue(4'd2, 4'd10, 4'd1);
    repeat (4) @(negedge clk);
    check("mid_q_before_rst", int'(q), 4);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst_release");
    exp_q = 0;

    // Randomized sweeps against the model
    for (int i = 0; i < 20; i++) begin
      rs = 4'($urandom_range(0, 15));
      re = 4'($urandom_range(0, 15));
      rr = 4'($urandom_range(1, 3));
      issue(rs, re, rr);
      trace(rs, re, rr, 0, bn, tn);
      len = (re >= rs) ? int'(re) - int'(rs) + 1 : int'(rs) - int'(re) + 1;
      exp_busy = 1 + int'(rr) * len;
      check($sformatf("rnd%0d_busy_cycles", i), bn, exp_busy);
      check($sformatf("rnd%0d_tc_count", i), tn, int'(rr));
    end

`ifdef SWEEP_PRESCALE_EN
    presc_v = 2;
    issue(4'd1, 4'd3, 4'd1);
    trace(4'd1, 4'd3, 4'd1, 2, bn, tn);
    check("presc2_busy_cycles", bn, 10);
    check("presc2_tc_count", tn, 1);
    for (int i = 0; i < 4; i++) begin
      presc_v = int'($urandom_range(0, 3));
      rs = 4'($urandom_range(0, 15));
      re = 4'($urandom_range(0, 15));
      rr = 4'($urandom_range(1, 2));
      issue(rs, re, rr);
      trace(rs, re, rr, presc_v, bn, tn);
      len = (re >= rs) ? int'(re) - int'(rs) + 1 : int'(rs) - int'(re) + 1;
      check($sformatf("presc_rnd%0d_busy", i), bn, 1 + int'(rr) * len * (presc_v + 1));
    end
    presc_v = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
